// File: rtl/fpga_robots_game_lockmon.sv
// Lock monitor for the game clock domain: synchronizes two PLL lock
// indications, holds the game in reset until lock has been stable for
// SETTLE_CYCLES, and re-runs the reset sequence on lock loss or restart.
module fpga_robots_game_lockmon #(
  parameter int unsigned SETTLE_CYCLES    = 1024,
  parameter int unsigned MIN_RESET_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lock1_async,
  input  logic       lock2_async,
  input  logic       restart,
  output logic       game_rst_n,
  output logic [1:0] state,
  output logic [7:0] lost_count
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned LOST_W = 8;

  // Terminal counts; the shared counter runs 0..N-1 inside a state.
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST   = CNT_W'(MIN_RESET_CYCLES - 1);
  localparam logic [LOST_W-1:0] LOST_MAX    = {LOST_W{1'b1}};

  typedef enum logic [1:0] {
    ST_WAIT   = 2'b00,
    ST_SETTLE = 2'b01,
    ST_RUN    = 2'b10,
    ST_HOLD   = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LOST_W-1:0]   lost_q, lost_d;
  logic                game_rst_n_q, game_rst_n_d;
  logic [1:0]          sync1_q, sync2_q;
  logic                lock_ok;

  // Two-flop synchronizers, one per lock input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {sync1_q[0], lock1_async};
      sync2_q <= {sync2_q[0], lock2_async};
    end
  end

  // Qualified lock: both PLLs locked as seen after synchronization.
  assign lock_ok = sync1_q[1] & sync2_q[1];

  // State, shared counter, lost counter and game reset registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_WAIT;
      cnt_q        <= '0;
      lost_q       <= '0;
      game_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lost_q       <= lost_d;
      game_rst_n_q <= game_rst_n_d;
    end
  end

  // Next-state logic; cnt clears on every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lost_d  = lost_q;

    case (state_q)
      ST_WAIT: begin
        if (lock_ok) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
      end

      ST_SETTLE: begin
        if (!lock_ok) begin
          // Lock dropped before the game ever ran: not a loss event.
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RUN: begin
        if (!lock_ok) begin
          // Lock loss wins over a coincident restart and is counted once.
          state_d = ST_HOLD;
          cnt_d   = '0;
          if (lost_q != LOST_MAX) begin
            lost_d = lost_q + LOST_W'(1);
          end
        end else if (restart) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end

      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
    endcase

    // Game reset is released exactly while the registered state is RUN.
    game_rst_n_d = (state_d == ST_RUN);
  end

  assign state      = state_q;
  assign lost_count = lost_q;
  assign game_rst_n = game_rst_n_q;

endmodule

// File: tb/tb_fpga_robots_game_lockmon.sv
// Directed bench for the lock monitor with SETTLE_CYCLES=8, MIN_RESET_CYCLES=4.
module tb_fpga_robots_game_lockmon;

  localparam logic [1:0] S_WAIT   = 2'b00;
  localparam logic [1:0] S_SETTLE = 2'b01;
  localparam logic [1:0] S_RUN    = 2'b10;
  localparam logic [1:0] S_HOLD   = 2'b11;

  logic       clk;
  logic       rst_n;
  logic       lock1_async;
  logic       lock2_async;
  logic       restart;
  logic       game_rst_n;
  logic [1:0] state;
  logic [7:0] lost_count;

  int total = 0;
  int bad   = 0;
  int exp_lost = 0;

  fpga_robots_game_lockmon #(
    .SETTLE_CYCLES(8),
    .MIN_RESET_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .lock1_async(lock1_async),
    .lock2_async(lock2_async),
    .restart(restart),
    .game_rst_n(game_rst_n),
    .state(state),
    .lost_count(lost_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n active edges, then sample 1ns later.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bounded wait for a target state; an expired budget is a failure.
  task automatic wait_state(input logic [1:0] tgt, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (state === tgt) break;
      tick(1);
    end
    total++;
    if (state !== tgt) begin
      bad++;
      $display("FAIL %s timeout state=%0d want=%0d", name, state, tgt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; lock1_async = 1'b1; lock2_async = 1'b1; restart = 1'b0;
    tick(3);
    total++;
    if (state !== S_WAIT) begin bad++; $display("FAIL reset_state got=%0d want=%0d", state, S_WAIT); end
    total++;
    if (game_rst_n !== 1'b0) begin bad++; $display("FAIL reset_grn got=%b want=0", game_rst_n); end
    total++;
    if (lost_count !== 8'd0) begin bad++; $display("FAIL reset_lost got=%0d want=0", lost_count); end
  endtask

  task automatic test_bringup();
    rst_n = 1'b1;
    tick(2);
    total++;
    if (state !== S_WAIT) begin bad++; $display("FAIL bringup_e2 state=%0d want=%0d", state, S_WAIT); end
    tick(1);
    total++;
    if (state !== S_SETTLE) begin bad++; $display("FAIL bringup_e3 state=%0d want=%0d", state, S_SETTLE); end
    tick(7);
    total++;
    if (state !== S_SETTLE || game_rst_n !== 1'b0) begin
      bad++; $display("FAIL bringup_e10 state=%0d grn=%b want=%0d/0", state, game_rst_n, S_SETTLE);
    end
    tick(1);
    total++;
    if (state !== S_RUN || game_rst_n !== 1'b1) begin
      bad++; $display("FAIL bringup_e11 state=%0d grn=%b want=%0d/1", state, game_rst_n, S_RUN);
    end
    total++;
    if (lost_count !== 8'd0) begin bad++; $display("FAIL bringup_lost got=%0d want=0", lost_count); end
  endtask

  task automatic test_lock_loss();
    lock2_async = 1'b0;
    tick(2);
    total++;
    if (state !== S_RUN || game_rst_n !== 1'b1) begin
      bad++; $display("FAIL loss_e2 state=%0d grn=%b want=%0d/1", state, game_rst_n, S_RUN);
    end
    tick(1);
    exp_lost = 1;
    total++;
    if (state !== S_HOLD || game_rst_n !== 1'b0) begin
      bad++; $display("FAIL loss_e3 state=%0d grn=%b want=%0d/0", state, game_rst_n, S_HOLD);
    end
    total++;
    if (lost_count !== 8'(exp_lost)) begin bad++; $display("FAIL loss_count got=%0d want=%0d", lost_count, exp_lost); end
    lock2_async = 1'b1;
    tick(3);
    total++;
    if (state !== S_HOLD) begin bad++; $display("FAIL loss_e6 state=%0d want=%0d", state, S_HOLD); end
    tick(1);
    total++;
    if (state !== S_WAIT) begin bad++; $display("FAIL loss_e7 state=%0d want=%0d", state, S_WAIT); end
    tick(1);
    total++;
    if (state !== S_SETTLE) begin bad++; $display("FAIL loss_e8 state=%0d want=%0d", state, S_SETTLE); end
    tick(8);
    total++;
    if (state !== S_RUN || game_rst_n !== 1'b1) begin
      bad++; $display("FAIL loss_rerun state=%0d grn=%b want=%0d/1", state, game_rst_n, S_RUN);
    end
  endtask

  task automatic test_restart();
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    total++;
    if (state !== S_HOLD || game_rst_n !== 1'b0) begin
      bad++; $display("FAIL restart_hold state=%0d grn=%b want=%0d/0", state, game_rst_n, S_HOLD);
    end
    total++;
    if (lost_count !== 8'(exp_lost)) begin bad++; $display("FAIL restart_lost got=%0d want=%0d", lost_count, exp_lost); end
    tick(12);
    total++;
    if (state !== S_SETTLE) begin bad++; $display("FAIL restart_e12 state=%0d want=%0d", state, S_SETTLE); end
    tick(1);
    total++;
    if (state !== S_RUN || game_rst_n !== 1'b1) begin
      bad++; $display("FAIL restart_e13 state=%0d grn=%b want=%0d/1", state, game_rst_n, S_RUN);
    end
  endtask

  task automatic test_settle_glitch();
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    tick(5);
    total++;
    if (state !== S_SETTLE) begin bad++; $display("FAIL glitch_entry state=%0d want=%0d", state, S_SETTLE); end
    // Restart is ignored outside RUN.
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    tick(2);
    total++;
    if (state !== S_SETTLE) begin bad++; $display("FAIL glitch_restart_ign state=%0d want=%0d", state, S_SETTLE); end
    lock1_async = 1'b0;
    tick(1);
    lock1_async = 1'b1;
    tick(1);
    total++;
    if (state !== S_SETTLE) begin bad++; $display("FAIL glitch_e2 state=%0d want=%0d", state, S_SETTLE); end
    tick(1);
    total++;
    if (state !== S_WAIT || lost_count !== 8'(exp_lost)) begin
      bad++; $display("FAIL glitch_wait state=%0d lost=%0d want=%0d/%0d", state, lost_count, S_WAIT, exp_lost);
    end
    tick(1);
    total++;
    if (state !== S_SETTLE) begin bad++; $display("FAIL glitch_resettle state=%0d want=%0d", state, S_SETTLE); end
    tick(7);
    total++;
    if (state !== S_SETTLE) begin bad++; $display("FAIL glitch_full_settle state=%0d want=%0d", state, S_SETTLE); end
    tick(1);
    total++;
    if (state !== S_RUN) begin bad++; $display("FAIL glitch_run state=%0d want=%0d", state, S_RUN); end
  endtask

  task automatic test_coincident();
    lock1_async = 1'b0;
    tick(2);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    lock1_async = 1'b1;
    exp_lost = exp_lost + 1;
    total++;
    if (state !== S_HOLD || lost_count !== 8'(exp_lost)) begin
      bad++; $display("FAIL coincident state=%0d lost=%0d want=%0d/%0d", state, lost_count, S_HOLD, exp_lost);
    end
    wait_state(S_RUN, 40, "coincident_rerun");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      lock2_async = 1'b0;
      wait_state(S_HOLD, 10, "sat_hold");
      lock2_async = 1'b1;
      exp_lost = (exp_lost >= 255) ? 255 : exp_lost + 1;
      total++;
      if (lost_count !== 8'(exp_lost)) begin
        bad++; $display("FAIL sat_count iter=%0d got=%0d want=%0d", i, lost_count, exp_lost);
      end
      wait_state(S_RUN, 40, "sat_rerun");
    end
    total++;
    if (lost_count !== 8'd255) begin bad++; $display("FAIL sat_final got=%0d want=255", lost_count); end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    tick(1);
    total++;
    if (game_rst_n !== 1'b0 || lost_count !== 8'd0 || state !== S_WAIT) begin
      bad++; $display("FAIL rst_mid_run grn=%b lost=%0d state=%0d want=0/0/0", game_rst_n, lost_count, state);
    end
    rst_n = 1'b1;
    tick(2);
    total++;
    if (state !== S_WAIT) begin bad++; $display("FAIL rst_refill state=%0d want=%0d", state, S_WAIT); end
    wait_state(S_RUN, 20, "rst_rerun");
    lock1_async = 1'b0;
    wait_state(S_HOLD, 10, "rst_hold");
    total++;
    if (lost_count !== 8'd1) begin bad++; $display("FAIL rst_hold_lost got=%0d want=1", lost_count); end
    tick(1);
    rst_n = 1'b0;
    tick(1);
    total++;
    if (game_rst_n !== 1'b0 || lost_count !== 8'd0 || state !== S_WAIT) begin
      bad++; $display("FAIL rst_mid_hold grn=%b lost=%0d state=%0d want=0/0/0", game_rst_n, lost_count, state);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    lock1_async = 1'b0;
    lock2_async = 1'b0;
    restart = 1'b0;
    test_reset();
    test_bringup();
    test_lock_loss();
    test_restart();
    test_settle_glitch();
    test_coincident();
    test_saturation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
